data_read_axi_fifo: RTL

DATA_READ_AXI_FIFO -- requirements
Module: data_read_axi_fifo

---
 rtl/data_read_axi_fifo_if.sv | 34 +++
 rtl/data_read_axi_fifo.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/data_read_axi_fifo_if.sv
// AXI4-Lite register bus for the capture FIFO: address, data, response and read channels.
interface data_read_axi_fifo_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/data_read_axi_fifo.sv
// Capture FIFO drained over AXI4-Lite: DATA pop, STATUS with W1C stickies, CTRL, THRESH, level IRQ.
//   state     | meaning
//   CH_IDLE   | no request seen, ready low
//   CH_ACCEPT | ready high for one cycle, request taken if still valid
//   CH_RESP   | response valid, held until the master takes it
module data_read_axi_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  data_read_axi_fifo_if.slave   s_axi,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {CH_IDLE, CH_ACCEPT, CH_RESP} ch_state_t;

  ch_state_t wr_state, wr_next, rd_state, rd_next;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  ctrl_en, ovf_q, ufl_q, irq_q;
  logic [15:0]           thresh_q;
  logic [31:0]           rdata_q, rd_word;

  logic       wr_fire, rd_fire;
  logic [1:0] wr_sel, rd_sel;
  logic       is_empty, is_full, flush, push_req, push, pop;
  logic       ovf_set, ufl_set, ovf_clr, ufl_clr;
  logic       unused_ok;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= CH_IDLE;
      rd_state <= CH_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    case (wr_state)
      CH_IDLE:   if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) wr_next = CH_ACCEPT;
      CH_ACCEPT: wr_next = (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) ? CH_RESP : CH_IDLE;
      CH_RESP:   if (s_axi.S_AXI_BREADY) wr_next = CH_IDLE;
      default:   wr_next = CH_IDLE;
    endcase
    case (rd_state)
      CH_IDLE:   if (s_axi.S_AXI_ARVALID) rd_next = CH_ACCEPT;
      CH_ACCEPT: rd_next = s_axi.S_AXI_ARVALID ? CH_RESP : CH_IDLE;
      CH_RESP:   if (s_axi.S_AXI_RREADY) rd_next = CH_IDLE;
      default:   rd_next = CH_IDLE;
    endcase
  end

  assign s_axi.S_AXI_AWREADY = (wr_state == CH_ACCEPT);
  assign s_axi.S_AXI_WREADY  = (wr_state == CH_ACCEPT);
  assign s_axi.S_AXI_BVALID  = (wr_state == CH_RESP);
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = (rd_state == CH_ACCEPT);
  assign s_axi.S_AXI_RVALID  = (rd_state == CH_RESP);
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign IRQ                 = irq_q;

  assign wr_fire  = (wr_state == CH_ACCEPT) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign rd_fire  = (rd_state == CH_ACCEPT) && s_axi.S_AXI_ARVALID;
  assign wr_sel   = s_axi.S_AXI_AWADDR[3:2];
  assign rd_sel   = s_axi.S_AXI_ARADDR[3:2];

  assign is_empty = (level == '0);
  assign is_full  = (level == LW'(FIFO_DEPTH));
  assign flush    = wr_fire && (wr_sel == 2'd2) && s_axi.S_AXI_WDATA[1];
  // A flush on the same edge swallows any incoming word.
  assign push_req = IN_VALID && ctrl_en && !flush;
  assign pop      = rd_fire && (rd_sel == 2'd0) && !is_empty;
  assign push     = push_req && (!is_full || pop);
  assign ovf_set  = push_req && is_full && !pop;
  assign ufl_set  = rd_fire && (rd_sel == 2'd0) && is_empty;
  assign ovf_clr  = wr_fire && (wr_sel == 2'd1) && s_axi.S_AXI_WDATA[2];
  assign ufl_clr  = wr_fire && (wr_sel == 2'd1) && s_axi.S_AXI_WDATA[3];

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      2'd0:    rd_word = pop ? 32'(mem[rd_ptr]) : 32'd0;
      2'd1:    rd_word = {16'(level), 12'd0, ufl_q, ovf_q, is_full, is_empty};
      2'd2:    rd_word = {31'd0, ctrl_en};
      default: rd_word = {16'd0, thresh_q};
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ctrl_en  <= 1'b0;
      ovf_q    <= 1'b0;
      ufl_q    <= 1'b0;
      thresh_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end
      // Set events take priority over a same-edge W1C.
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
      ufl_q <= ufl_set | (ufl_q & ~ufl_clr);
      if (wr_fire && (wr_sel == 2'd2)) ctrl_en  <= s_axi.S_AXI_WDATA[0];
      if (wr_fire && (wr_sel == 2'd3)) thresh_q <= s_axi.S_AXI_WDATA[15:0];
      if (rd_fire) rdata_q <= rd_word;
      irq_q <= ovf_q | (ctrl_en && (thresh_q != 16'd0) && (16'(level) >= thresh_q));
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wr_ptr] <= IN_DATA;
  end

  assign unused_ok = ^{s_axi.S_AXI_AWADDR[31:4], s_axi.S_AXI_AWADDR[1:0],
                       s_axi.S_AXI_ARADDR[31:4], s_axi.S_AXI_ARADDR[1:0],
                       s_axi.S_AXI_WDATA[31:16], s_axi.S_AXI_WSTRB};
endmodule
